ddr_mem_tester: RTL and testbench
=================================

DDR_MEM_TESTER -- requirements
Module: ddr_mem_tester

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_W, 64, Avalon data width (multiple of 8); ADDR_W, 25, word address width; BURST_LEN, 4, beats per burst (power of two, 1..64); ERR_W, 32, error counter width.
REQ-002 clk_clk  in  1  sole clock; all logic rising-edge.
REQ-003 reset_reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  single-cycle request to begin a test; ignored unless idle.
REQ-005 mode  in  2  pattern: 0 address-as-data, 1 walking-one, 2 LFSR, 3 inverted address.
REQ-006 base_addr  in  ADDR_W  first word address; must be BURST_LEN-aligned.
REQ-007 num_bursts  in  ADDR_W  bursts to test; 0 means no access.
REQ-008 local_init_done, local_cal_success, local_cal_fail  in  1 each  EMIF status.
REQ-009 avm_address out ADDR_W; avm_write, avm_read out 1; avm_writedata out DATA_W; avm_byteenable out DATA_W/8; avm_burstcount out clog2(BURST_LEN)+1; avm_waitrequest in 1; avm_readdata in DATA_W; avm_readdatavalid in 1.
REQ-010 busy, done, pass  out  1; err_count  out  ERR_W; first_err_addr  out  ADDR_W; status_pio  out  4 = {pass, done, local_cal_fail, local_cal_success}.

Function
REQ-011 FSM states: IDLE, WAIT_CAL, WR_BURST, RD_REQ, RD_DATA, FINISH, CAL_FAIL.
REQ-012 IDLE -> WAIT_CAL on start; latches mode, base_addr, num_bursts; clears err_count, first_err_addr, done, pass.
REQ-013 WAIT_CAL -> WR_BURST when local_init_done && local_cal_success; -> CAL_FAIL if local_cal_fail; num_bursts==0 -> FINISH directly with pass=1.
REQ-014 WR_BURST: avm_write high with constant avm_address = burst base and avm_burstcount = BURST_LEN; beat advances only on cycle with avm_waitrequest low; writedata/write stable while waitrequest high.
REQ-015 After last beat of last burst -> RD_REQ at base_addr; byteenable all ones throughout.
REQ-016 RD_REQ: avm_read asserted one accepted cycle per burst, then RD_DATA; exactly one read burst outstanding.
REQ-017 RD_DATA: each readdatavalid beat compared against expected pattern for that word address; mismatch increments err_count (saturates at all ones) and records first_err_addr on the first mismatch only.
REQ-018 After BURST_LEN valid beats: next burst -> RD_REQ; last burst -> FINISH.
REQ-019 FINISH: done=1, pass=(err_count==0), busy=0, return to IDLE next cycle; done and pass hold until next accepted start.
REQ-020 CAL_FAIL: done=1, pass=0, returns to IDLE; err_count unchanged (0).
REQ-021 busy=1 in every state except IDLE; start while busy has no effect.
REQ-022 Patterns per word address a: mode 0 a zero-extended; 1 one-hot bit (a mod DATA_W); 2 LFSR seeded from a; 3 bitwise inverse of mode 0. Expected and written data identical functions of a.
REQ-023 Address arithmetic wraps modulo 2^ADDR_W; no bounds error.
REQ-024 readdatavalid outside RD_DATA is ignored.

Reset
REQ-025 On reset_reset: state IDLE; avm_write, avm_read, busy, done, pass = 0; err_count, first_err_addr, avm_address = 0; effective asynchronously mid-burst; no Avalon transfer completion guaranteed.

Configuration
REQ-026 TESTER_LFSR_EN defined: mode 2 uses 32-bit Galois LFSR (polynomial x^32+x^22+x^2+x+1) replicated to DATA_W; undefined: LFSR logic absent, mode 2 behaves as mode 0.

Structure
REQ-027 Package ddr_tester_pkg SHALL hold FSM state enum, mode enum, LFSR polynomial constant.
REQ-028 Sub-module ddr_tester_patgen (address, mode -> data), instantiated once for write data and once for expected data.

Verification
REQ-029 Cal ok, mode 0, base 0, num_bursts 8, no waitrequest -> 32 writes, 32 reads, done=1, pass=1, err_count=0.
REQ-030 Memory model flips bit 3 at word 0x13 and 0x15 -> err_count=2, first_err_addr=0x13, pass=0.
REQ-031 local_cal_fail=1 after start -> CAL_FAIL, done=1, pass=0, no avm_write.
REQ-032 Random waitrequest 50% during write -> writedata/address stable while stalled; final pass=1.
REQ-033 Reset asserted mid-WR_BURST -> avm_write=0, busy=0 immediately; later start runs cleanly.
REQ-034 num_bursts=0 -> done=1, pass=1 within 3 cycles, no Avalon traffic; mode 2 with/without TESTER_LFSR_EN both pass.

Source files
------------

// File: rtl/ddr_tester_pkg.sv
// Shared types and constants for the DDR memory tester.
package ddr_tester_pkg;

  // Tester FSM states
  typedef enum logic [2:0] {
    StIdle,
    StWaitCal,
    StWrBurst,
    StRdReq,
    StRdData,
    StFinish,
    StCalFail
  } state_e;

  // Data pattern selection
  typedef enum logic [1:0] {
    ModeAddr = 2'd0,
    ModeWalk = 2'd1,
    ModeLfsr = 2'd2,
    ModeInv  = 2'd3
  } mode_e;

  // Galois tap mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Mixed into the word address so that address 0 does not seed an all-zero LFSR
  localparam logic [31:0] LFSR_SEED_MIX = 32'hACE1_5EED;

  // One Galois LFSR step
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/ddr_tester_patgen.sv
// Word-address to test-data pattern generator. Purely combinational.
// Build option TESTER_LFSR_EN: mode 2 produces a replicated 32-bit LFSR word;
// without it, mode 2 falls back to the address-as-data pattern.
module ddr_tester_patgen
  import ddr_tester_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 25
) (
  input  logic [ADDR_W-1:0] addr,
  input  mode_e             mode,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] addr_ext;
  logic [31:0]       addr32;
  logic [31:0]       bit_idx;
  logic [DATA_W-1:0] walk;

  assign addr_ext = DATA_W'(addr);
  assign addr32   = 32'(addr);
  assign bit_idx  = addr32 % DATA_W;
  assign walk     = DATA_W'(1) << bit_idx;

`ifdef TESTER_LFSR_EN
  logic [31:0]       lfsr_word;
  logic [DATA_W-1:0] lfsr_data;

  assign lfsr_word = lfsr_step(addr32 ^ LFSR_SEED_MIX);

  // Replicate the 32-bit LFSR word across the full data width
  always_comb begin
    lfsr_data = '0;
    for (int i = 0; i < DATA_W; i++) begin
      lfsr_data[i] = lfsr_word[i % 32];
    end
  end
`endif

  // Select the pattern for this word address
  always_comb begin
    data = addr_ext;
    unique case (mode)
      ModeAddr: data = addr_ext;
      ModeWalk: data = walk;
`ifdef TESTER_LFSR_EN
      ModeLfsr: data = lfsr_data;
`else
      ModeLfsr: data = addr_ext;
`endif
      ModeInv:  data = ~addr_ext;
    endcase
  end

endmodule

// File: rtl/ddr_mem_tester.sv
// Avalon-MM burst memory tester for an EMIF DDR controller: writes a pattern
// over a burst-aligned region, reads it back one burst at a time and counts
// mismatching words. Build option TESTER_LFSR_EN enables the LFSR pattern.
module ddr_mem_tester
  import ddr_tester_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ADDR_W    = 25,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned ERR_W     = 32
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset,
  input  logic                         start,
  input  logic [1:0]                   mode,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [ADDR_W-1:0]            num_bursts,
  input  logic                         local_init_done,
  input  logic                         local_cal_success,
  input  logic                         local_cal_fail,
  output logic [ADDR_W-1:0]            avm_address,
  output logic                         avm_write,
  output logic                         avm_read,
  output logic [DATA_W-1:0]            avm_writedata,
  output logic [DATA_W/8-1:0]          avm_byteenable,
  output logic [$clog2(BURST_LEN):0]   avm_burstcount,
  input  logic                         avm_waitrequest,
  input  logic [DATA_W-1:0]            avm_readdata,
  input  logic                         avm_readdatavalid,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [ERR_W-1:0]             err_count,
  output logic [ADDR_W-1:0]            first_err_addr,
  output logic [3:0]                   status_pio
);

  localparam int unsigned         BEAT_W     = $clog2(BURST_LEN) + 1;
  localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0]   BEAT_ONE   = BEAT_W'(1);
  localparam logic [ADDR_W-1:0]   ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]   BURST_STEP = ADDR_W'(BURST_LEN);
  localparam logic [ERR_W-1:0]    ERR_ONE    = ERR_W'(1);

  state_e              state_q;
  mode_e               mode_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   num_q;
  logic [ADDR_W-1:0]   burst_cnt_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [ADDR_W-1:0]   wr_word_q;
  logic [ADDR_W-1:0]   rd_word_q;

  logic [ADDR_W-1:0]   wr_pat_addr;
  logic [DATA_W-1:0]   wr_pat_data;
  logic [DATA_W-1:0]   exp_data;
  logic                wr_accept;
  logic                rd_accept;
  logic                last_burst;
  logic                err_inc;
  logic [ERR_W-1:0]    err_next;

  assign avm_byteenable = '1;
  assign avm_burstcount = ($clog2(BURST_LEN) + 1)'(BURST_LEN);
  assign status_pio     = {pass, done, local_cal_fail, local_cal_success};

  assign wr_accept  = avm_write & ~avm_waitrequest;
  assign rd_accept  = avm_read & ~avm_waitrequest;
  assign last_burst = (burst_cnt_q == (num_q - ADDR_ONE));

  // Write data is registered one word ahead: the first word on entry, else the next word
  assign wr_pat_addr = (state_q == StWrBurst) ? (wr_word_q + ADDR_ONE) : base_q;

  ddr_tester_patgen #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_wr_patgen (
    .addr (wr_pat_addr),
    .mode (mode_q),
    .data (wr_pat_data)
  );

  ddr_tester_patgen #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_exp_patgen (
    .addr (rd_word_q),
    .mode (mode_q),
    .data (exp_data)
  );

  // Error accounting for the current read beat, saturating at all ones
  always_comb begin
    err_inc  = (state_q == StRdData) && avm_readdatavalid && (avm_readdata != exp_data);
    err_next = err_count;
    if (err_inc && (err_count != '1)) begin
      err_next = err_count + ERR_ONE;
    end
  end

  // Tester FSM with registered Avalon and status outputs
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q        <= StIdle;
      mode_q         <= ModeAddr;
      base_q         <= '0;
      num_q          <= '0;
      burst_cnt_q    <= '0;
      beat_q         <= '0;
      wr_word_q      <= '0;
      rd_word_q      <= '0;
      avm_address    <= '0;
      avm_write      <= 1'b0;
      avm_read       <= 1'b0;
      avm_writedata  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q        <= StWaitCal;
            mode_q         <= mode_e'(mode);
            base_q         <= base_addr;
            num_q          <= num_bursts;
            err_count      <= '0;
            first_err_addr <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b1;
          end
        end

        StWaitCal: begin
          if (local_cal_fail) begin
            state_q <= StCalFail;
            done    <= 1'b1;
            pass    <= 1'b0;
          end else if (num_q == '0) begin
            // Nothing to test: report success without touching memory
            state_q <= StFinish;
            done    <= 1'b1;
            pass    <= 1'b1;
            busy    <= 1'b0;
          end else if (local_init_done && local_cal_success) begin
            state_q       <= StWrBurst;
            avm_write     <= 1'b1;
            avm_address   <= base_q;
            wr_word_q     <= base_q;
            avm_writedata <= wr_pat_data;
            beat_q        <= '0;
            burst_cnt_q   <= '0;
          end
        end

        StWrBurst: begin
          if (wr_accept) begin
            if (beat_q == LAST_BEAT) begin
              beat_q <= '0;
              if (last_burst) begin
                state_q     <= StRdReq;
                avm_write   <= 1'b0;
                avm_read    <= 1'b1;
                avm_address <= base_q;
                burst_cnt_q <= '0;
              end else begin
                burst_cnt_q   <= burst_cnt_q + ADDR_ONE;
                avm_address   <= avm_address + BURST_STEP;
                wr_word_q     <= wr_word_q + ADDR_ONE;
                avm_writedata <= wr_pat_data;
              end
            end else begin
              beat_q        <= beat_q + BEAT_ONE;
              wr_word_q     <= wr_word_q + ADDR_ONE;
              avm_writedata <= wr_pat_data;
            end
          end
        end

        StRdReq: begin
          if (rd_accept) begin
            state_q   <= StRdData;
            avm_read  <= 1'b0;
            beat_q    <= '0;
            rd_word_q <= avm_address;
          end
        end

        StRdData: begin
          if (avm_readdatavalid) begin
            err_count <= err_next;
            // A saturating counter never returns to zero, so zero marks "no error yet"
            if (err_inc && (err_count == '0)) begin
              first_err_addr <= rd_word_q;
            end
            rd_word_q <= rd_word_q + ADDR_ONE;
            if (beat_q == LAST_BEAT) begin
              beat_q <= '0;
              if (last_burst) begin
                state_q <= StFinish;
                done    <= 1'b1;
                pass    <= (err_next == '0);
                busy    <= 1'b0;
              end else begin
                state_q     <= StRdReq;
                burst_cnt_q <= burst_cnt_q + ADDR_ONE;
                avm_address <= avm_address + BURST_STEP;
                avm_read    <= 1'b1;
              end
            end else begin
              beat_q <= beat_q + BEAT_ONE;
            end
          end
        end

        StFinish: begin
          state_q <= StIdle;
        end

        StCalFail: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_mem_tester.sv
// Self-checking bench for ddr_mem_tester: directed table, randomized runs
// against an address-range memory model, and a mid-burst reset sequence.
module tb_ddr_mem_tester;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 25;
  localparam int BL     = 4;
  localparam int ERR_W  = 32;

  logic                clk;
  logic                reset_reset;
  logic                start;
  logic [1:0]          mode;
  logic [ADDR_W-1:0]   base_addr;
  logic [ADDR_W-1:0]   num_bursts;
  logic                local_init_done;
  logic                local_cal_success;
  logic                local_cal_fail;
  logic [ADDR_W-1:0]   avm_address;
  logic                avm_write;
  logic                avm_read;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic [2:0]          avm_burstcount;
  logic                avm_waitrequest;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_readdatavalid;
  logic                busy;
  logic                done;
  logic                pass;
  logic [ERR_W-1:0]    err_count;
  logic [ADDR_W-1:0]   first_err_addr;
  logic [3:0]          status_pio;

  ddr_mem_tester u_dut (
    .clk_clk           (clk),
    .reset_reset       (reset_reset),
    .start             (start),
    .mode              (mode),
    .base_addr         (base_addr),
    .num_bursts        (num_bursts),
    .local_init_done   (local_init_done),
    .local_cal_success (local_cal_success),
    .local_cal_fail    (local_cal_fail),
    .avm_address       (avm_address),
    .avm_write         (avm_write),
    .avm_read          (avm_read),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_burstcount    (avm_burstcount),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .err_count         (err_count),
    .first_err_addr    (first_err_addr),
    .status_pio        (status_pio)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

`ifdef TESTER_LFSR_EN
  function automatic logic [63:0] lfsr_ref(input logic [24:0] a);
    int          ex [4] = '{32, 22, 2, 1};
    logic [31:0] taps;
    logic [31:0] s;
    taps = '0;
    foreach (ex[i]) taps[ex[i]-1] = 1'b1;
    s = {7'd0, a} ^ 32'hACE1_5EED;
    s = s[0] ? ((s >> 1) ^ taps) : (s >> 1);
    return {s, s};
  endfunction
`endif

  // Reference data pattern for a word address
  function automatic logic [63:0] pat(input logic [24:0] a, input int m);
    logic [63:0] z;
    z = {39'd0, a};
    case (m)
      1: pat = 64'd1 << (a % 25'd64);
`ifdef TESTER_LFSR_EN
      2: pat = lfsr_ref(a);
`else
      2: pat = z;
`endif
      3: pat = ~z;
      default: pat = z;
    endcase
  endfunction

  // ---------------- Avalon slave / memory model ----------------
  logic [63:0]   mem [int unsigned];
  logic [24:0]   rd_q [$];
  logic [24:0]   flips [$];
  int            wait_pct;
  int            cur_mode;
  logic [24:0]   exp_base;
  int            wr_beats, wr_in_burst, wr_bad, stall_bad;
  int            rd_bursts, rd_beats, rd_bad;
  logic          stalled;
  logic [24:0]   st_addr;
  logic [63:0]   st_data;

  function automatic bit is_flip(input logic [24:0] a);
    foreach (flips[i]) if (flips[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_slave();
    mem.delete();
    rd_q.delete();
    wr_beats = 0; wr_in_burst = 0; wr_bad = 0; stall_bad = 0;
    rd_bursts = 0; rd_beats = 0; rd_bad = 0;
    stalled = 1'b0;
  endtask

  initial begin
    logic [24:0] a;
    logic [24:0] ea;
    logic [63:0] d;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    wait_pct          = 0;
    clear_slave();
    forever begin
      @(negedge clk);
      if (reset_reset) begin
        rd_q.delete();
        stalled           = 1'b0;
        wr_in_burst       = 0;
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;
      end else begin
        if (stalled && !(avm_write && avm_address == st_addr && avm_writedata == st_data))
          stall_bad++;
        // Return data before accepting a new command so a beat never lands in RD_REQ
        avm_readdatavalid = 1'b0;
        avm_readdata      = {$urandom(), $urandom()};
        if (rd_q.size() > 0) begin
          if ($urandom_range(99) >= 25) begin
            a = rd_q.pop_front();
            d = mem.exists(int'(a)) ? mem[int'(a)] : 64'd0;
            if (is_flip(a)) d ^= 64'h8;
            avm_readdata      = d;
            avm_readdatavalid = 1'b1;
            rd_beats++;
          end
        end else if ($urandom_range(3) == 0) begin
          avm_readdatavalid = 1'b1;  // stray beat the tester must ignore
        end
        avm_waitrequest = ($urandom_range(99) < wait_pct);
        if (avm_write && !avm_waitrequest) begin
          a  = avm_address + 25'(wr_in_burst);
          ea = exp_base + 25'(wr_beats);
          if (a !== ea || avm_writedata !== pat(ea, cur_mode) ||
              avm_byteenable !== 8'hFF || avm_burstcount !== 3'd4) wr_bad++;
          mem[int'(a)] = avm_writedata;
          wr_beats++;
          wr_in_burst = (wr_in_burst + 1) % BL;
        end
        if (avm_read && !avm_waitrequest) begin
          if (rd_q.size() != 0) rd_bad++;
          if (avm_address !== exp_base + 25'(rd_bursts * BL)) rd_bad++;
          if (avm_burstcount !== 3'd4) rd_bad++;
          for (int i = 0; i < BL; i++) rd_q.push_back(avm_address + 25'(i));
          rd_bursts++;
        end
        stalled = avm_write && avm_waitrequest;
        st_addr = avm_address;
        st_data = avm_writedata;
      end
    end
  end

  // ---------------- Test vectors ----------------
  typedef struct {
    int          mode;
    logic [24:0] base;
    logic [24:0] nb;
    bit          cal_fail;
    int          nflip;
    logic [24:0] f0;
    logic [24:0] f1;
    int          wpct;
    bit          restart;
    bit          e_pass;
    int          e_err;
    logic [24:0] e_first;
    int          e_wr;
  } vec_t;

  function automatic vec_t mkv(int m, logic [24:0] b, logic [24:0] n, bit cf, int nf,
                               logic [24:0] f0, logic [24:0] f1, int w, bit rs, bit ep,
                               int ee, logic [24:0] efa, int ew);
    vec_t v;
    v.mode = m; v.base = b; v.nb = n; v.cal_fail = cf; v.nflip = nf; v.f0 = f0; v.f1 = f1;
    v.wpct = w; v.restart = rs; v.e_pass = ep; v.e_err = ee; v.e_first = efa; v.e_wr = ew;
    return v;
  endfunction

  // Expected outcome derived from the region covered and which words are corrupted
  function automatic vec_t model(vec_t v);
    logic [24:0] offs [2];
    logic [24:0] fa   [2];
    int          span;
    logic [24:0] best;
    span = int'(v.nb) * BL;
    fa[0] = v.f0; fa[1] = v.f1;
    v.e_err = 0; v.e_first = '0; best = '1;
    for (int i = 0; i < v.nflip; i++) begin
      offs[i] = fa[i] - v.base;
      if (int'(offs[i]) < span) begin
        v.e_err++;
        if (offs[i] < best) begin best = offs[i]; v.e_first = fa[i]; end
      end
    end
    v.e_pass = (v.e_err == 0);
    v.e_wr   = v.cal_fail ? 0 : span;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    bit seen;
    int budget;
    @(negedge clk);
    #1;
    clear_slave();
    cur_mode = v.mode; exp_base = v.base; wait_pct = v.wpct;
    flips.delete();
    if (v.nflip > 0) flips.push_back(v.f0);
    if (v.nflip > 1) flips.push_back(v.f1);
    local_init_done   = 1'b1;
    local_cal_fail    = v.cal_fail;
    local_cal_success = !v.cal_fail;
    start = 1'b1; mode = 2'(v.mode); base_addr = v.base; num_bursts = v.nb;
    @(negedge clk);
    start = 1'b0;
    mode = 2'($urandom_range(3)); base_addr = 25'($urandom()); num_bursts = 25'($urandom());
    budget = (v.nb == 0 || v.cal_fail) ? 3 : 60 + int'(v.nb) * BL * 10;
    seen = 1'b0;
    for (int c = 0; c <= budget; c++) begin
      if (done) begin seen = 1'b1; break; end
      if (v.restart && c == 5) begin
        start = 1'b1; mode = 2'd3; base_addr = '0; num_bursts = 25'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, ".done_seen"}, 64'(seen), 64'd1);
    @(negedge clk);
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".pass"}, 64'(pass), 64'(v.e_pass));
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".err_count"}, 64'(err_count), 64'(v.e_err));
    chk({tag, ".first_err"}, 64'(first_err_addr), 64'(v.e_first));
    chk({tag, ".wr_beats"}, 64'(wr_beats), 64'(v.e_wr));
    chk({tag, ".rd_beats"}, 64'(rd_beats), 64'(v.e_wr));
    chk({tag, ".wr_bad"}, 64'(wr_bad), 64'd0);
    chk({tag, ".stall_bad"}, 64'(stall_bad), 64'd0);
    chk({tag, ".rd_bad"}, 64'(rd_bad), 64'd0);
    chk({tag, ".status_pio"}, 64'(status_pio),
        64'({v.e_pass, 1'b1, v.cal_fail, !v.cal_fail}));
  endtask

  vec_t tbl [8];

  initial begin
    vec_t v;
    bit   seen;
    tbl[0] = mkv(0, 25'h0,       25'd8, 0, 0, 0, 0,            0,  0, 1, 0, 25'h0,  32);
    tbl[1] = mkv(0, 25'h0,       25'd8, 0, 2, 25'h13, 25'h15,  0,  0, 0, 2, 25'h13, 32);
    tbl[2] = mkv(0, 25'h0,       25'd8, 1, 0, 0, 0,            0,  0, 0, 0, 25'h0,  0);
    tbl[3] = mkv(1, 25'h40,      25'd4, 0, 0, 0, 0,            50, 0, 1, 0, 25'h0,  16);
    tbl[4] = mkv(2, 25'h80,      25'd0, 0, 0, 0, 0,            0,  0, 1, 0, 25'h0,  0);
    tbl[5] = mkv(3, 25'h1FFFFF8, 25'd4, 0, 0, 0, 0,            30, 0, 1, 0, 25'h0,  16);
    tbl[6] = mkv(2, 25'h100,     25'd3, 0, 0, 0, 0,            20, 1, 1, 0, 25'h0,  12);
    tbl[7] = mkv(1, 25'h20,      25'd2, 0, 2, 25'h28, 25'h21,  0,  0, 0, 1, 25'h21, 8);

    reset_reset = 1'b1; start = 1'b0; mode = '0; base_addr = '0; num_bursts = '0;
    local_init_done = 1'b1; local_cal_success = 1'b1; local_cal_fail = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    reset_reset = 1'b0;
    @(negedge clk);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.pass", 64'(pass), 64'd0);
    chk("rst.write_read", 64'({avm_write, avm_read}), 64'd0);
    chk("rst.err_count", 64'(err_count), 64'd0);
    chk("rst.first_err", 64'(first_err_addr), 64'd0);
    chk("rst.address", 64'(avm_address), 64'd0);
    chk("rst.status_pio", 64'(status_pio), 64'b0001);

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    for (int r = 0; r < 6; r++) begin
      v.mode    = int'($urandom_range(3));
      v.base    = 25'($urandom()) & 25'h1FFFFFC;
      v.nb      = 25'($urandom_range(5, 1));
      v.cal_fail = 1'b0;
      v.nflip   = int'($urandom_range(2));
      v.f0      = v.base + 25'($urandom_range(int'(v.nb) * BL + 3));
      v.f1      = v.base + 25'($urandom_range(int'(v.nb) * BL + 3));
      if (v.f1 == v.f0 && v.nflip == 2) v.nflip = 1;
      v.wpct    = int'($urandom_range(60));
      v.restart = 1'b0;
      v = model(v);
      run_vec(v, $sformatf("rand%0d", r));
    end

    // Reset in the middle of the write phase
    @(negedge clk);
    #1;
    clear_slave();
    cur_mode = 0; exp_base = '0; wait_pct = 50; flips.delete();
    local_cal_fail = 1'b0; local_cal_success = 1'b1;
    start = 1'b1; mode = 2'd0; base_addr = '0; num_bursts = 25'd8;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (avm_write && wr_beats >= 5) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk("midrst.reached_write", 64'(seen), 64'd1);
    #2 reset_reset = 1'b1;
    #1;
    chk("midrst.write", 64'(avm_write), 64'd0);
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.address", 64'(avm_address), 64'd0);
    @(negedge clk);
    #2 reset_reset = 1'b0;
    run_vec(tbl[0], "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
